// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: bus widths, the NOP
// word returned for masked fetches, and the loader FSM state encodings.
`timescale 1ns/1ps
package inst_rom_loader_pkg;

  localparam int INSTADDRBUS = 32;
  localparam int INSTBUS     = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef logic [1:0] ld_state_t;

  localparam ld_state_t S_IDLE = 2'd0;
  localparam ld_state_t S_LOAD = 2'd1;
  localparam ld_state_t S_RUN  = 2'd2;
  localparam ld_state_t S_ERR  = 2'd3;

endpackage

// File: rtl/inst_rom_loader_rom_array.sv
// Instruction storage: one synchronous write port, one asynchronous read
// port, no reset so contents survive a reset and stay cheap to map to RAM.
`timescale 1ns/1ps
module inst_rom_loader_rom_array
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = INSTBUS
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Store the incoming load word on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Zero-latency read of the addressed word.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction-memory responder with a runtime program loader. A host pushes
// words over a valid/ready stream; the CPU is held until a complete program
// (terminated by i_ld_last) has been written, then fetches are served
// combinationally from the array.
`timescale 1ns/1ps
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = INSTADDRBUS,
  parameter int DATA_W     = INSTBUS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rom_ce,
  input  logic [ADDR_W-1:0]     i_rom_addr,
  output logic [DATA_W-1:0]     o_rom_data,
  input  logic                  i_ld_start,
  input  logic                  i_ld_valid,
  input  logic [DATA_W-1:0]     i_ld_data,
  input  logic                  i_ld_last,
  output logic                  o_ld_ready,
  output logic [DEPTH_LOG2:0]   o_ld_count,
  output logic                  o_ld_err,
  output logic                  o_cpu_hold
);

  localparam int unsigned         DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] LAST_SLOT  = (DEPTH_LOG2+1)'(DEPTH - 1);

  ld_state_t             state_r;
  ld_state_t             state_nxt_s;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  err_r;
  logic                  err_nxt_s;
  logic                  hold_r;
  logic                  we_s;
  logic                  ready_s;
  logic                  fetch_ok_s;
  logic [DATA_W-1:0]     rdata_s;
  logic [DATA_W-1:0]     rom_data_s;
  logic [1:0]            unused_addr_s;

  // Byte-offset bits carry no meaning for word fetches.
  assign unused_addr_s = i_rom_addr[1:0];

  // Ready only while loading; a start pulse in the same cycle drops the word.
  always_comb begin
    if ((state_r == S_LOAD) && !i_ld_start) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Next-state, counter and error-flag logic for the loader FSM.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    err_nxt_s   = err_r;
    we_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_ld_start) begin
          state_nxt_s = S_LOAD;
          count_nxt_s = COUNT_ZERO;
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (i_ld_start) begin
          state_nxt_s = S_LOAD;
          count_nxt_s = COUNT_ZERO;
        end else if (i_ld_valid) begin
          we_s        = 1'b1;
          count_nxt_s = count_r + COUNT_ONE;
          if (i_ld_last) begin
            state_nxt_s = S_RUN;
          end else if (count_r == LAST_SLOT) begin
            // Array is full and the program has not ended.
            state_nxt_s = S_ERR;
            err_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = S_LOAD;
          end
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_RUN, S_ERR: begin
        if (i_ld_start) begin
          state_nxt_s = S_LOAD;
          count_nxt_s = COUNT_ZERO;
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        count_nxt_s = COUNT_ZERO;
        err_nxt_s   = 1'b0;
      end
    endcase
  end

  // Loader state registers; hold is registered from the next state so it
  // changes exactly with the state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      count_r <= COUNT_ZERO;
      err_r   <= 1'b0;
      hold_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      err_r   <= err_nxt_s;
      hold_r  <= (state_nxt_s != S_RUN);
    end
  end

  inst_rom_loader_rom_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_rom_array (
    .clk   (clk),
    .we    (we_s),
    .waddr (count_r[DEPTH_LOG2-1:0]),
    .wdata (i_ld_data),
    .raddr (i_rom_addr[DEPTH_LOG2+1:2]),
    .rdata (rdata_s)
  );

  // Fetch is served only when enabled, the CPU is released and the address
  // lies inside the array; anything else returns a NOP.
  always_comb begin
    fetch_ok_s = i_rom_ce && !hold_r &&
                 (i_rom_addr[ADDR_W-1:DEPTH_LOG2+2] == '0);
    if (fetch_ok_s) begin
      rom_data_s = rdata_s;
    end else begin
      rom_data_s = NOP_INST;
    end
  end

  assign o_rom_data = rom_data_s;
  assign o_ld_ready = ready_s;
  assign o_ld_count = count_r;
  assign o_ld_err   = err_r;
  assign o_cpu_hold = hold_r;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: stimulus pushes expected
// observations into a queue, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_inst_rom_loader;
  import inst_rom_loader_pkg::*;

  localparam int SEL_ROM   = 0;
  localparam int SEL_HOLD  = 1;
  localparam int SEL_READY = 2;
  localparam int SEL_COUNT = 3;
  localparam int SEL_ERR   = 4;
  localparam int SEL_STATE = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rom_ce;
  logic [31:0] i_rom_addr;
  logic [31:0] o_rom_data;
  logic        i_ld_start;
  logic        i_ld_valid;
  logic [31:0] i_ld_data;
  logic        i_ld_last;
  logic        o_ld_ready;
  logic [10:0] o_ld_count;
  logic        o_ld_err;
  logic        o_cpu_hold;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          checks = 0;
  int          errors = 0;

  inst_rom_loader dut (
    .clk        (clk),
    .rst        (rst),
    .i_rom_ce   (i_rom_ce),
    .i_rom_addr (i_rom_addr),
    .o_rom_data (o_rom_data),
    .i_ld_start (i_ld_start),
    .i_ld_valid (i_ld_valid),
    .i_ld_data  (i_ld_data),
    .i_ld_last  (i_ld_last),
    .o_ld_ready (o_ld_ready),
    .o_ld_count (o_ld_count),
    .o_ld_err   (o_ld_err),
    .o_cpu_hold (o_cpu_hold)
  );

  always #5 clk = ~clk;

  // Monitor: drain every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.sel)
        SEL_ROM:   mon_act = o_rom_data;
        SEL_HOLD:  mon_act = {31'd0, o_cpu_hold};
        SEL_READY: mon_act = {31'd0, o_ld_ready};
        SEL_COUNT: mon_act = {21'd0, o_ld_count};
        SEL_ERR:   mon_act = {31'd0, o_ld_err};
        default:   mon_act = {30'd0, dut.state_r};
      endcase
      checks = checks + 1;
      if (mon_act !== mon_e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %h want %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input string name, input logic ce, input logic [31:0] addr,
                       input logic [31:0] exp);
    i_rom_ce   = ce;
    i_rom_addr = addr;
    #1;
    push(name, SEL_ROM, exp);
    check_now();
  endtask

  task automatic pulse_start();
    i_ld_start = 1'b1;
    step();
    i_ld_start = 1'b0;
  endtask

  // Backpressure table: valid pattern with junk data/last on idle cycles.
  logic        bp_valid [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        bp_last  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] bp_data  [5] = '{32'hB000_0000, 32'hDEAD_BEEF, 32'hB000_0001,
                                32'hDEAD_BEEF, 32'hB000_0002};

  initial begin
    rst        = 1'b0;
    i_rom_ce   = 1'b0;
    i_rom_addr = 32'h0;
    i_ld_start = 1'b0;
    i_ld_valid = 1'b0;
    i_ld_data  = 32'h0;
    i_ld_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    i_rom_ce = 1'b1;
    push("rst_hold",  SEL_HOLD,  32'd1);
    push("rst_ready", SEL_READY, 32'd0);
    push("rst_count", SEL_COUNT, 32'd0);
    push("rst_err",   SEL_ERR,   32'd0);
    push("rst_state", SEL_STATE, {30'd0, S_IDLE});
    fetch("rst_fetch", 1'b1, 32'h0, 32'h0);

    // Normal three-word load
    step();
    pulse_start();
    push("ld_ready", SEL_READY, 32'd1);
    push("ld_hold",  SEL_HOLD,  32'd1);
    check_now();
    i_ld_valid = 1'b1;
    i_ld_data = 32'h3401_0001; i_ld_last = 1'b0; step();
    i_ld_data = 32'h3402_0002; step();
    i_ld_data = 32'h0022_1820; i_ld_last = 1'b1; step();
    i_ld_valid = 1'b0; i_ld_last = 1'b0;
    push("ld_count", SEL_COUNT, 32'd3);
    push("ld_hold0", SEL_HOLD,  32'd0);
    push("ld_state", SEL_STATE, {30'd0, S_RUN});
    push("run_rdy",  SEL_READY, 32'd0);
    fetch("fetch_0", 1'b1, 32'h0, 32'h3401_0001);
    fetch("fetch_4", 1'b1, 32'h4, 32'h3402_0002);
    fetch("fetch_8", 1'b1, 32'h8, 32'h0022_1820);
    fetch("fetch_A", 1'b1, 32'hA, 32'h0022_1820);

    // Masking in S_RUN
    fetch("mask_ce0", 1'b0, 32'h0, 32'h0);
    fetch("mask_oor", 1'b1, 32'h0000_1000, 32'h0);

    // Start pulse in S_RUN: hold reasserts only after the edge
    step();
    i_rom_ce = 1'b1; i_rom_addr = 32'h0;
    i_ld_start = 1'b1;
    push("run_start_pre", SEL_HOLD, 32'd0);
    check_now();
    step();
    i_ld_start = 1'b0;
    push("run_start_hold",  SEL_HOLD,  32'd1);
    push("run_start_ready", SEL_READY, 32'd1);
    fetch("run_start_fetch", 1'b1, 32'h0, 32'h0);

    // Backpressure / gaps
    for (int i = 0; i < 5; i++) begin
      i_ld_valid = bp_valid[i];
      i_ld_last  = bp_last[i];
      i_ld_data  = bp_data[i];
      step();
    end
    i_ld_valid = 1'b0; i_ld_last = 1'b0;
    push("bp_count", SEL_COUNT, 32'd3);
    push("bp_hold",  SEL_HOLD,  32'd0);
    fetch("bp_fetch_0", 1'b1, 32'h0, 32'hB000_0000);
    fetch("bp_fetch_4", 1'b1, 32'h4, 32'hB000_0001);
    fetch("bp_fetch_8", 1'b1, 32'h8, 32'hB000_0002);

    // Restart inside S_LOAD drops the same-cycle word
    step();
    pulse_start();
    i_ld_valid = 1'b1; i_ld_data = 32'hC000_0000; i_ld_last = 1'b0;
    step();
    i_ld_data = 32'hC000_0001; i_ld_start = 1'b1;
    push("restart_ready", SEL_READY, 32'd0);
    check_now();
    step();
    i_ld_start = 1'b0; i_ld_valid = 1'b0;
    push("restart_count", SEL_COUNT, 32'd0);
    push("restart_rdy1",  SEL_READY, 32'd1);
    check_now();
    i_ld_valid = 1'b1; i_ld_data = 32'hC000_0002; i_ld_last = 1'b1;
    step();
    i_ld_valid = 1'b0; i_ld_last = 1'b0;
    push("restart_cnt1", SEL_COUNT, 32'd1);
    push("restart_hold", SEL_HOLD,  32'd0);
    fetch("restart_fetch_0", 1'b1, 32'h0, 32'hC000_0002);
    fetch("restart_fetch_4", 1'b1, 32'h4, 32'hB000_0001);

    // Asynchronous reset mid-load
    step();
    pulse_start();
    i_ld_valid = 1'b1; i_ld_data = 32'hD000_0000; i_ld_last = 1'b0;
    step();
    i_ld_valid = 1'b0;
    #2;
    rst = 1'b0;
    push("arst_hold",  SEL_HOLD,  32'd1);
    push("arst_count", SEL_COUNT, 32'd0);
    push("arst_state", SEL_STATE, {30'd0, S_IDLE});
    push("arst_ready", SEL_READY, 32'd0);
    check_now();
    step();
    rst = 1'b1;
    step();
    push("arst_hold2", SEL_HOLD, 32'd1);
    fetch("arst_fetch", 1'b1, 32'h0, 32'h0);

    // Overflow: 1024 words without last, then the 1025th is refused
    pulse_start();
    i_ld_valid = 1'b1; i_ld_last = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      i_ld_data = 32'hF000_0000 | i;
      step();
    end
    i_ld_data = 32'hF000_0400;
    push("ovf_ready", SEL_READY, 32'd0);
    push("ovf_err",   SEL_ERR,   32'd1);
    push("ovf_count", SEL_COUNT, 32'd1024);
    push("ovf_hold",  SEL_HOLD,  32'd1);
    push("ovf_state", SEL_STATE, {30'd0, S_ERR});
    check_now();
    step();
    push("ovf_sticky", SEL_ERR,   32'd1);
    push("ovf_cnt2",   SEL_COUNT, 32'd1024);
    check_now();
    i_ld_valid = 1'b0;
    step();
    pulse_start();
    push("ovf_clr_err",   SEL_ERR,   32'd0);
    push("ovf_clr_count", SEL_COUNT, 32'd0);
    push("ovf_clr_ready", SEL_READY, 32'd1);
    check_now();

    // Full load with last on the 1024th word ends in S_RUN
    i_ld_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      i_ld_data = 32'hE000_0000 | i;
      i_ld_last = (i == 1023);
      step();
    end
    i_ld_valid = 1'b0; i_ld_last = 1'b0;
    push("full_hold",  SEL_HOLD,  32'd0);
    push("full_err",   SEL_ERR,   32'd0);
    push("full_count", SEL_COUNT, 32'd1024);
    push("full_state", SEL_STATE, {30'd0, S_RUN});
    fetch("full_fetch_ffc", 1'b1, 32'h0000_0FFC, 32'hE000_03FF);
    fetch("full_fetch_4",   1'b1, 32'h0000_0004, 32'hE000_0001);
    fetch("full_fetch_oor", 1'b1, 32'h0000_1000, 32'h0);
    fetch("full_fetch_hi",  1'b1, 32'h8000_0000, 32'h0);

    step();
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder on the far side of the CPU fetch port: answers rom_ce/rom_addr with a same-cycle instruction word.
- Filled at runtime by a host-side valid/ready word stream, e.g. from a UART or testbench loader.
- Holds the CPU off through o_cpu_hold until a complete program has been written.
- Sits beside MIPSCPU at SoC top; o_cpu_hold is ORed into the CPU's reset.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words stored (1024 words).
- ADDR_W, 32, width of the fetch byte address.
- DATA_W, 32, instruction/word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_rom_ce  in  1  fetch enable from CPU pc stage.
- i_rom_addr  in  ADDR_W  fetch byte address from CPU.
- o_rom_data  out  DATA_W  instruction word to CPU, combinational.
- i_ld_start  in  1  one-cycle pulse; begins a new program load.
- i_ld_valid  in  1  load word valid.
- i_ld_data  in  DATA_W  load word.
- i_ld_last  in  1  qualifies the final word of the program.
- o_ld_ready  out  1  loader can accept a word.
- o_ld_count  out  DEPTH_LOG2+1  words written in current/last load.
- o_ld_err  out  1  overflow sticky flag.
- o_cpu_hold  out  1  keep CPU in reset/stall.

Behaviour:
- Reset (rst=0, async): state=S_IDLE, o_cpu_hold=1, o_ld_ready=0, o_ld_count=0, o_ld_err=0. Memory array is not cleared.
- FSM states: S_IDLE, S_LOAD, S_RUN, S_ERR.
- S_IDLE: hold=1, ready=0. i_ld_start -> S_LOAD next cycle, count<=0, err<=0.
- S_LOAD: hold=1, ready=1.
  - Accept = valid & ready. On accept, write i_ld_data to word[count] at the clock edge; count<=count+1.
  - Accept with i_ld_last=1 -> S_RUN, including when it is the 2^DEPTH_LOG2-th word.
  - Accept while count==2^DEPTH_LOG2-1 with last=0: word is written, count<=2^DEPTH_LOG2, then -> S_ERR.
  - i_ld_start in S_LOAD restarts: count<=0. A same-cycle valid word is dropped; ready is driven 0 that cycle.
- S_RUN: hold=0, ready=0. i_ld_start -> S_LOAD; hold reasserts the next cycle.
- S_ERR: hold=1, ready=0, err=1 (sticky). Only i_ld_start -> S_LOAD, clearing err and count; otherwise only reset leaves S_ERR.
- Fetch read path:
  - Combinational, zero latency: o_rom_data = word[i_rom_addr[DEPTH_LOG2+1:2]].
  - o_rom_data = 32'h0 (NOP) when any of: i_rom_ce=0; o_cpu_hold=1; i_rom_addr[ADDR_W-1:DEPTH_LOG2+2] != 0 (out of range).
  - Low two address bits are ignored; no alignment fault.
- Read/write conflict: impossible by construction, since reads are masked while hold=1. A write to word[k] is visible to a fetch in the first cycle after S_RUN is entered.
- Reset mid-load: FSM returns to S_IDLE, count=0, partially written words remain in the array. The CPU stays held until a fresh complete load.
- o_ld_count is registered and holds its final value in S_RUN and S_ERR.

Decomposition:
- Shared package (define.sv family) holds:
  - ld_state_t enum {S_IDLE, S_LOAD, S_RUN, S_ERR}.
  - NOP_INST constant 32'h0.
  - INSTADDRBUS / INSTBUS widths reused for ADDR_W / DATA_W.
- One sub-module, rom_array: DEPTH=2^DEPTH_LOG2 x DATA_W, synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata), no reset.
- The FSM, counter and read masking live in inst_rom_loader.

Test Plan:
- Reset, then i_rom_ce=1, addr=0 -> o_rom_data=0, o_cpu_hold=1, o_ld_ready=0.
- Normal load and fetch:
  - Stimulus: start pulse, then 3 words 0x34010001, 0x34020002, 0x00221820 (last on the 3rd).
  - Required: count=3, S_RUN next cycle, hold=0.
  - Fetches with ce=1 at addr 0x0/0x4/0x8/0xA return those words; addr 0x8 and 0xA both return 0x00221820.
- Backpressure/gaps: valid toggles 1,0,1,0,1 with last on the 3rd word -> exactly 3 writes, count=3, no word duplicated.
- Masking in S_RUN:
  - ce=0 -> 0.
  - addr = 0x00001000 (word 1024, out of range) -> 0.
  - addr = 0x00000FFC -> word 1023.
- Overflow: 1025 valid words with last never asserted -> the 1025th cycle has ready=0, err=1, count=1024, hold=1. A start pulse then clears err and count=0.
- Mid-operation events:
  - rst=0 asserted asynchronously mid-load, between clock edges -> hold=1 and count=0 immediately; the state reads S_IDLE.
  - Start pulse in S_RUN -> hold=1 next cycle, fetch data=0.
